// File: rtl/rs_pkg.sv
// Shared reservation-station types: issue packet layout, FU select encodings
// and the port-to-class map used by the issue-select stage.
package rs_pkg;
  localparam int BR_MASK_W = 4;
  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int SQ_IDX_W  = 3;

  localparam int FU_SEL_W = 3;
  localparam logic [FU_SEL_W-1:0] FU_SEL_ALU  = 3'd0;
  localparam logic [FU_SEL_W-1:0] FU_SEL_MULT = 3'd1;
  localparam logic [FU_SEL_W-1:0] FU_SEL_BR   = 3'd2;
  localparam logic [FU_SEL_W-1:0] FU_SEL_MEM  = 3'd3;
  localparam logic [FU_SEL_W-1:0] FU_SEL_NONE = 3'd7;

  // Issue port f serves fu_sel value FU_CLASS[f]
  localparam int FU_CLASS_NUM = 4;
  localparam logic [FU_CLASS_NUM-1:0][FU_SEL_W-1:0] FU_CLASS =
    {FU_SEL_MEM, FU_SEL_BR, FU_SEL_MULT, FU_SEL_ALU};

  typedef struct packed {
    logic [PRF_IDX_W-1:0] opa_tag;
    logic [PRF_IDX_W-1:0] opb_tag;
    logic [PRF_IDX_W-1:0] dest_tag;
    logic [31:0]          ir;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [BR_MASK_W-1:0] br_mask;
    logic [SQ_IDX_W-1:0]  sq_position;
    logic                 ldl;
    logic [31:0]          npc;
    logic                 br_pre_taken;
    logic [31:0]          br_target;
    logic [BR_MASK_W-1:0] br_mask_1hot;
  } iss_pkt_t;

  function automatic logic br_hit(input logic [BR_MASK_W-1:0] mask,
                                  input logic [BR_MASK_W-1:0] tag);
    return |(mask & tag);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = W'(j);
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_issue_sel.sv
// Issue select: one round-robin pick per FU class per cycle into a per-port
// issue/execute register, with FU back-pressure and branch squash/fix.
module rs_issue_sel
  import rs_pkg::*;
#(
  parameter  int RS_NUM = 16,
  parameter  int FU_NUM = 4,
  localparam int PTR_W  = $clog2(RS_NUM),
  localparam int CNT_W  = $clog2(FU_NUM+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [RS_NUM-1:0]                ent_rdy_i,
  input  logic [RS_NUM-1:0][FU_SEL_W-1:0]  ent_fu_sel_i,
  input  iss_pkt_t [RS_NUM-1:0]            ent_pkt_i,
  input  logic [FU_NUM-1:0]                fu_stall_i,
  input  logic                             br_pred_correct_i,
  input  logic                             br_recovery_i,
  input  logic [BR_MASK_W-1:0]             br_tag_fix_i,
  output logic [RS_NUM-1:0]                ent_iss_en_o,
  output logic [FU_NUM-1:0]                iss_vld_o,
  output iss_pkt_t [FU_NUM-1:0]            iss_pkt_o,
  output logic [CNT_W-1:0]                 iss_cnt_o
);
  logic [RS_NUM-1:0]             kill;
  logic [FU_NUM-1:0][RS_NUM-1:0] cand, gnt;
  logic [FU_NUM-1:0][PTR_W-1:0]  rr_ptr, sel;
  logic [FU_NUM-1:0]             any, adv, iss;

  always_comb begin
    kill = '0;
    cand = '0;
    for (int i = 0; i < RS_NUM; i++)
      kill[i] = br_recovery_i & br_hit(ent_pkt_i[i].br_mask, br_tag_fix_i);
    for (int f = 0; f < FU_NUM; f++)
      for (int i = 0; i < RS_NUM; i++)
        cand[f][i] = ent_rdy_i[i] & (ent_fu_sel_i[i] == FU_CLASS[f]) & ~kill[i];
  end

  for (genvar f = 0; f < FU_NUM; f++) begin : g_arb
    rr_arbiter #(.N(RS_NUM)) u_arb (
      .req (cand[f]),
      .ptr (rr_ptr[f]),
      .gnt (gnt[f]),
      .idx (sel[f]),
      .any (any[f])
    );
  end

  // A port frees up only on the currently registered valid, not on a squash
  // landing this same cycle.
  assign adv = ~iss_vld_o | ~fu_stall_i;
  assign iss = {FU_NUM{~rst}} & adv & any;

  always_comb begin
    ent_iss_en_o = '0;
    iss_cnt_o    = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      if (iss[f]) ent_iss_en_o = ent_iss_en_o | gnt[f];
      iss_cnt_o = iss_cnt_o + CNT_W'(iss[f]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_o <= '0;
      iss_pkt_o <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int f = 0; f < FU_NUM; f++) begin
        if (!adv[f]) begin
          // Held packet: recovery wins over a simultaneous correct-predict
          if (br_recovery_i && br_hit(iss_pkt_o[f].br_mask, br_tag_fix_i))
            iss_vld_o[f] <= 1'b0;
          else if (br_pred_correct_i && !br_recovery_i)
            iss_pkt_o[f].br_mask <= iss_pkt_o[f].br_mask & ~br_tag_fix_i;
        end else begin
          iss_vld_o[f] <= any[f];
          if (any[f]) begin
            iss_pkt_o[f] <= ent_pkt_i[sel[f]];
            rr_ptr[f]    <= (sel[f] == PTR_W'(RS_NUM-1)) ? '0 : sel[f] + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_sel.sv
// Bench for rs_issue_sel: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural port model.
module tb_rs_issue_sel;
  import rs_pkg::*;

  localparam int RS = 16;
  localparam int FN = 4;
  localparam int PW = $bits(iss_pkt_t);

  logic                          clk = 1'b0;
  logic                          rst;
  logic [RS-1:0]                 rdy;
  logic [RS-1:0][FU_SEL_W-1:0]   fsel;
  iss_pkt_t [RS-1:0]             pkt;
  logic [FN-1:0]                 stall;
  logic                          corr, rec;
  logic [BR_MASK_W-1:0]          tag;
  logic [RS-1:0]                 en;
  logic [FN-1:0]                 vld;
  iss_pkt_t [FN-1:0]             opkt;
  logic [2:0]                    cnt;

  rs_issue_sel #(.RS_NUM(RS), .FU_NUM(FN)) dut (
    .clk               (clk),
    .rst               (rst),
    .ent_rdy_i         (rdy),
    .ent_fu_sel_i      (fsel),
    .ent_pkt_i         (pkt),
    .fu_stall_i        (stall),
    .br_pred_correct_i (corr),
    .br_recovery_i     (rec),
    .br_tag_fix_i      (tag),
    .ent_iss_en_o      (en),
    .iss_vld_o         (vld),
    .iss_pkt_o         (opkt),
    .iss_cnt_o         (cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic iss_pkt_t mkpkt(input logic [BR_MASK_W-1:0] m);
    logic [159:0] r;
    iss_pkt_t     p;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    p = iss_pkt_t'(r[PW-1:0]);
    p.br_mask = m;
    return p;
  endfunction

  // Behavioural model: what each port holds, and where its scan starts
  bit       mvld [FN];
  iss_pkt_t mpkt [FN];
  int       mptr [FN];
  bit       nv   [FN];
  iss_pkt_t npkt [FN];
  int       nptr [FN];
  bit       synced = 1'b0;
  logic [RS-1:0] xen;
  int       xcnt;

  // Called at negedge with inputs applied; checks, then steps one clock.
  task automatic tick();
    int s, i;
    #1;
    xen  = '0;
    xcnt = 0;
    for (int f = 0; f < FN; f++) begin
      nv[f] = mvld[f]; npkt[f] = mpkt[f]; nptr[f] = mptr[f];
      if (rst) begin
        nv[f] = 1'b0; npkt[f] = '0; nptr[f] = 0;
      end else if (mvld[f] && stall[f]) begin
        if (rec && ((mpkt[f].br_mask & tag) != 0)) nv[f] = 1'b0;
        else if (corr && !rec) npkt[f].br_mask = mpkt[f].br_mask & ~tag;
      end else begin
        s = -1;
        for (int k = 0; k < RS; k++) begin
          i = (mptr[f] + k) % RS;
          if (s < 0 && rdy[i] && int'(fsel[i]) == f &&
              !(rec && ((pkt[i].br_mask & tag) != 0)))
            s = i;
        end
        if (s >= 0) begin
          xen[s] = 1'b1; xcnt++;
          nv[f] = 1'b1; npkt[f] = pkt[s]; nptr[f] = (s + 1) % RS;
        end else begin
          nv[f] = 1'b0;
        end
      end
    end
    chk("iss_en", 160'(en), 160'(xen));
    chk("iss_cnt", 160'(cnt), 160'(xcnt));
    if (synced) begin
      for (int f = 0; f < FN; f++) begin
        chk($sformatf("iss_vld[%0d]", f), 160'(vld[f]), 160'(mvld[f]));
        if (mvld[f])
          chk($sformatf("iss_pkt[%0d]", f), {{(160-PW){1'b0}}, opkt[f]},
              {{(160-PW){1'b0}}, mpkt[f]});
      end
    end
    @(posedge clk);
    for (int f = 0; f < FN; f++) begin
      mvld[f] = nv[f]; mpkt[f] = npkt[f]; mptr[f] = nptr[f];
    end
    if (rst) synced = 1'b1;
    @(negedge clk);
  endtask

  logic [RS-1:0] rr_exp [5];
  iss_pkt_t      p_keep;

  initial begin
    rr_exp = '{16'h0004, 16'h0020, 16'h0200, 16'h1000, 16'h0002};
    for (int f = 0; f < FN; f++) begin mvld[f] = 1'b0; mpkt[f] = '0; mptr[f] = 0; end
    rst = 1'b1; rdy = '1; stall = '0; corr = 1'b0; rec = 1'b0; tag = '0;
    for (int i = 0; i < RS; i++) begin fsel[i] = FU_SEL_ALU; pkt[i] = mkpkt(4'b0000); end
    @(negedge clk);

    // Reset with everything ready: nothing may issue
    repeat (2) begin
      #1 chk("rst_en", 160'(en), 160'(0));
      chk("rst_cnt", 160'(cnt), 160'(0));
      tick();
      #1 chk("rst_vld", 160'(vld), 160'(0));
    end
    rst = 1'b0;
    #1 chk("first_alu", 160'(en), 160'(16'h0001));
    tick();

    // Round robin across ALU entries, cleared as they issue
    rdy = 16'h0224;
    for (int j = 0; j < 5; j++) begin
      if (j == 3) rdy = 16'h1002;
      #1 chk("rr_order", 160'(en), 160'(rr_exp[j]));
      tick();
      rdy = rdy & ~rr_exp[j];
    end

    // All four classes in parallel
    for (int i = 0; i < RS; i++) fsel[i] = FU_SEL_NONE;
    fsel[3] = FU_SEL_ALU; fsel[4] = FU_SEL_MULT; fsel[7] = FU_SEL_MEM; fsel[8] = FU_SEL_BR;
    rdy = 16'h0198;
    #1 chk("par_en", 160'(en), 160'(16'h0198));
    chk("par_cnt", 160'(cnt), 160'(4));
    p_keep = pkt[4];
    tick();
    rdy = '0;
    #1 chk("par_vld", 160'(vld), 160'(4'hF));

    // MULT port stalled while entry 6 waits
    stall[1] = 1'b1; fsel[6] = FU_SEL_MULT; pkt[6] = mkpkt(4'b0000); rdy[6] = 1'b1;
    repeat (3) begin
      #1 chk("stall_en", 160'(en), 160'(0));
      chk("stall_vld", 160'(vld[1]), 160'(1));
      chk("stall_hold", {{(160-PW){1'b0}}, opkt[1]}, {{(160-PW){1'b0}}, p_keep});
      tick();
    end
    stall[1] = 1'b0;
    #1 chk("unstall_en", 160'(en), 160'(16'h0040));
    tick();
    rdy = '0;
    #1 chk("unstall_pkt", {{(160-PW){1'b0}}, opkt[1]}, {{(160-PW){1'b0}}, pkt[6]});

    // Recovery squashes a stalled ALU packet and blocks a killed entry
    fsel[0] = FU_SEL_ALU; pkt[0] = mkpkt(4'b0110); rdy[0] = 1'b1;
    #1 chk("rec_setup_en", 160'(en), 160'(16'h0001));
    tick();
    rdy = '0;
    stall[0] = 1'b1; rec = 1'b1; tag = 4'b0100;
    fsel[5] = FU_SEL_ALU; pkt[5] = mkpkt(4'b0100); rdy[5] = 1'b1;
    #1 chk("rec_stall_en", 160'(en), 160'(0));
    tick();
    #1 chk("rec_squash", 160'(vld[0]), 160'(0));
    stall[0] = 1'b0;
    #1 chk("rec_kill_en", 160'(en), 160'(0));
    tick();
    rec = 1'b0; tag = '0;
    #1 chk("rec_after_en", 160'(en), 160'(16'h0020));
    tick();
    rdy = '0;

    // Correct prediction clears the resolved bit in a held BR packet
    fsel[9] = FU_SEL_BR; pkt[9] = mkpkt(4'b0011); rdy[9] = 1'b1;
    #1 chk("cor_setup_en", 160'(en), 160'(16'h0200));
    tick();
    rdy = '0; stall[2] = 1'b1; corr = 1'b1; tag = 4'b0001;
    tick();
    corr = 1'b0; tag = '0;
    #1 chk("cor_mask", 160'(opkt[2].br_mask), 160'(4'b0010));
    chk("cor_vld", 160'(vld[2]), 160'(1));
    stall = '0;

    // Random traffic against the model
    repeat (3000) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = RS'($urandom);
      for (int i = 0; i < RS; i++) begin
        int r;
        r = int'($urandom_range(0, 4));
        fsel[i] = (r == 4) ? FU_SEL_NONE : FU_SEL_W'(r);
        pkt[i]  = mkpkt(BR_MASK_W'($urandom));
      end
      stall = FN'($urandom);
      rec   = ($urandom_range(0, 7) == 0);
      corr  = ($urandom_range(0, 3) == 0);
      tag   = BR_MASK_W'(1 << $urandom_range(0, BR_MASK_W-1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
